// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: synchronizes and filters the PS/2 lines, decodes device-to-host frames
// and assembles 3-byte movement packets into one-cycle delta strobes plus held button states.
module ps2_mouse_packet_rx #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_mid,
  output logic       packet_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FiltMax = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] ToMax   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic [FW-1:0] filt_cnt;
  logic          filt_q, filt_prev_q;
  logic          fall;

  // Synchronizers idle high so reset does not look like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_cnt    <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      filt_prev_q <= filt_q;
      if (clk_s2 != filt_q) begin
        if (filt_cnt == FiltMax) begin
          filt_q   <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign fall = filt_prev_q & ~filt_q;

  state_e        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_ok_q, par_ok_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    b0_q, b0_d, b1_q, b1_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [8:0]    xm_q, xm_d, ym_q, ym_d;
  logic [2:0]    btn_q, btn_d;
  logic          pv_q, pv_d, err_q, err_d;
  logic          active;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_ok_d = par_ok_q;
    idx_d    = idx_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    to_cnt_d = to_cnt_q;
    btn_d    = btn_q;
    xm_d     = '0;
    ym_d     = '0;
    pv_d     = 1'b0;
    err_d    = 1'b0;
    active   = (state_q != StIdle) || (idx_q != 2'd0);

    if (fall) begin
      to_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!dat_s2) begin
            state_d  = StData;
            bitcnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        StData: begin
          shreg_d  = {dat_s2, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = StParity;
        end
        StParity: begin
          par_ok_d = ^{shreg_q, dat_s2};
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (dat_s2 && par_ok_q) begin
            unique case (idx_q)
              2'd0: begin
                // Bit 3 is always set in a first byte; anything else means lost alignment.
                if (shreg_q[3]) begin
                  b0_d  = shreg_q;
                  idx_d = 2'd1;
                end
              end
              2'd1: begin
                b1_d  = shreg_q;
                idx_d = 2'd2;
              end
              2'd2: begin
                idx_d = 2'd0;
                pv_d  = 1'b1;
                xm_d  = b0_q[6] ? 9'd0 : {b0_q[4], b1_q};
                ym_d  = b0_q[7] ? 9'd0 : {b0_q[5], shreg_q};
                btn_d = b0_q[2:0];
              end
              default: idx_d = 2'd0;
            endcase
          end else begin
            err_d = 1'b1;
            idx_d = 2'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (active) begin
      if (to_cnt_q == ToMax) begin
        state_d  = StIdle;
        idx_d    = 2'd0;
        err_d    = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      par_ok_q <= 1'b0;
      idx_q    <= 2'd0;
      b0_q     <= '0;
      b1_q     <= '0;
      to_cnt_q <= '0;
      xm_q     <= '0;
      ym_q     <= '0;
      btn_q    <= '0;
      pv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      par_ok_q <= par_ok_d;
      idx_q    <= idx_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      to_cnt_q <= to_cnt_d;
      xm_q     <= xm_d;
      ym_q     <= ym_d;
      btn_q    <= btn_d;
      pv_q     <= pv_d;
      err_q    <= err_d;
    end
  end

  assign xm           = xm_q;
  assign ym           = ym_q;
  assign btn_left     = btn_q[0];
  assign btn_right    = btn_q[1];
  assign btn_mid      = btn_q[2];
  assign packet_valid = pv_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_ps2_mouse_packet_rx.sv
// Directed bench for ps2_mouse_packet_rx: drives PS/2 frames bit by bit and checks strobes,
// deltas, buttons, error pulses and strobe latency against hand-computed values.
module tb_ps2_mouse_packet_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [8:0] xm, ym;
  logic       btn_left, btn_right, btn_mid, packet_valid, frame_err;

  ps2_mouse_packet_rx #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(2000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .xm          (xm),
    .ym          (ym),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_mid     (btn_mid),
    .packet_valid(packet_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Free-running cycle count and event monitor sampled on the falling clock edge.
  int         cyc = 0;
  int         pv_cnt = 0, err_cnt = 0, nz_bad = 0, both_bad = 0;
  int         pv_cyc = 0;
  int         stop_cyc = 0;
  logic [8:0] last_xm = '0, last_ym = '0;
  logic [2:0] last_btn = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (packet_valid === 1'b1) begin
      pv_cnt   <= pv_cnt + 1;
      pv_cyc   <= cyc;
      last_xm  <= xm;
      last_ym  <= ym;
      last_btn <= {btn_mid, btn_right, btn_left};
    end else if (xm !== 9'd0 || ym !== 9'd0) begin
      nz_bad <= nz_bad + 1;
    end
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
    if (packet_valid === 1'b1 && frame_err === 1'b1) both_bad <= both_bad + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends start, 8 data bits LSB first, parity, stop; nbits < 11 truncates the frame.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_clk(20);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_clk(40);
      ps2_clk = 1'b1;
      wait_clk(20);
    end
    ps2_data = 1'b1;
    wait_clk(20);
  endtask

  task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_frame(b0, 1'b0, 11);
    send_frame(b1, 1'b0, 11);
    send_frame(b2, 1'b0, 11);
    wait_clk(20);
  endtask

  task automatic test_reset;
    wait_clk(3);
    checks++;
    if ({xm, ym, btn_mid, btn_right, btn_left, packet_valid, frame_err} !== 23'd0)
      $display("FAIL reset_outputs: got %h want 0",
               {xm, ym, btn_mid, btn_right, btn_left, packet_valid, frame_err});
    else passes++;
    rst = 1'b0;
    wait_clk(50);
    checks++;
    if (pv_cnt !== 0 || err_cnt !== 0)
      $display("FAIL reset_quiet: pv=%0d err=%0d want 0 0", pv_cnt, err_cnt);
    else passes++;
  endtask

  task automatic test_valid_packet;
    int pv0, nz0;
    pv0 = pv_cnt;
    nz0 = nz_bad;
    send_packet(8'h29, 8'h05, 8'hFE);
    checks++;
    if (pv_cnt - pv0 !== 1) $display("FAIL valid_count: got %0d want 1", pv_cnt - pv0);
    else passes++;
    checks++;
    if (last_xm !== 9'h005) $display("FAIL valid_xm: got %h want 005", last_xm);
    else passes++;
    checks++;
    if (last_ym !== 9'h1FE) $display("FAIL valid_ym: got %h want 1fe", last_ym);
    else passes++;
    checks++;
    if (last_btn !== 3'b001) $display("FAIL valid_btn: got %b want 001", last_btn);
    else passes++;
    // 2 sync + 4 filter samples + fall register + output register = 7 edges after the pin falls.
    checks++;
    if (pv_cyc - stop_cyc !== 7)
      $display("FAIL valid_latency: got %0d want 7", pv_cyc - stop_cyc);
    else passes++;
    checks++;
    if (nz_bad - nz0 !== 0) $display("FAIL valid_zero_deltas: got %0d want 0", nz_bad - nz0);
    else passes++;
    checks++;
    if ({btn_mid, btn_right, btn_left} !== 3'b001)
      $display("FAIL valid_btn_held: got %b want 001", {btn_mid, btn_right, btn_left});
    else passes++;
  endtask

  task automatic test_parity_error;
    int pv0, err0;
    pv0  = pv_cnt;
    err0 = err_cnt;
    send_frame(8'h09, 1'b0, 11);
    send_frame(8'h01, 1'b1, 11);
    wait_clk(20);
    checks++;
    if (err_cnt - err0 !== 1 || pv_cnt - pv0 !== 0)
      $display("FAIL parity_err: err=%0d pv=%0d want 1 0", err_cnt - err0, pv_cnt - pv0);
    else passes++;
    send_packet(8'h09, 8'h01, 8'h02);
    checks++;
    if (pv_cnt - pv0 !== 1 || last_xm !== 9'h001 || last_ym !== 9'h002)
      $display("FAIL parity_recover: pv=%0d xm=%h ym=%h want 1 001 002",
               pv_cnt - pv0, last_xm, last_ym);
    else passes++;
  endtask

  task automatic test_resync;
    int pv0, err0;
    pv0  = pv_cnt;
    err0 = err_cnt;
    send_frame(8'h05, 1'b0, 11);
    send_packet(8'h08, 8'h10, 8'h20);
    checks++;
    if (pv_cnt - pv0 !== 1 || err_cnt - err0 !== 0)
      $display("FAIL resync_count: pv=%0d err=%0d want 1 0", pv_cnt - pv0, err_cnt - err0);
    else passes++;
    checks++;
    if (last_xm !== 9'h010 || last_ym !== 9'h020 || last_btn !== 3'b000)
      $display("FAIL resync_data: xm=%h ym=%h btn=%b want 010 020 000",
               last_xm, last_ym, last_btn);
    else passes++;
  endtask

  task automatic test_overflow;
    int pv0;
    pv0 = pv_cnt;
    send_packet(8'h58, 8'h33, 8'h44);
    checks++;
    if (pv_cnt - pv0 !== 1 || last_xm !== 9'h000 || last_ym !== 9'h044)
      $display("FAIL overflow: pv=%0d xm=%h ym=%h want 1 000 044",
               pv_cnt - pv0, last_xm, last_ym);
    else passes++;
  endtask

  task automatic test_timeout;
    int pv0, err0;
    pv0  = pv_cnt;
    err0 = err_cnt;
    send_frame(8'h3B, 1'b0, 11);
    send_frame(8'h7F, 1'b0, 5);
    wait_clk(1900);
    checks++;
    if (err_cnt - err0 !== 0)
      $display("FAIL timeout_early: err=%0d want 0", err_cnt - err0);
    else passes++;
    wait_clk(200);
    checks++;
    if (err_cnt - err0 !== 1 || pv_cnt - pv0 !== 0)
      $display("FAIL timeout_err: err=%0d pv=%0d want 1 0", err_cnt - err0, pv_cnt - pv0);
    else passes++;
    send_packet(8'h3B, 8'h7F, 8'h80);
    checks++;
    if (pv_cnt - pv0 !== 1 || last_xm !== 9'h17F || last_ym !== 9'h180 || last_btn !== 3'b011)
      $display("FAIL timeout_recover: pv=%0d xm=%h ym=%h btn=%b want 1 17f 180 011",
               pv_cnt - pv0, last_xm, last_ym, last_btn);
    else passes++;
  endtask

  task automatic test_glitch;
    int pv0, err0;
    pv0  = pv_cnt;
    err0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0;
      wait_clk(2);
      ps2_clk = 1'b1;
      wait_clk(30);
    end
    checks++;
    if (err_cnt - err0 !== 0) $display("FAIL glitch_idle: err=%0d want 0", err_cnt - err0);
    else passes++;
    send_frame(8'h2C, 1'b0, 11);
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0;
      wait_clk(2);
      ps2_clk = 1'b1;
      wait_clk(30);
    end
    send_frame(8'h01, 1'b0, 11);
    send_frame(8'hFF, 1'b0, 11);
    wait_clk(20);
    checks++;
    if (pv_cnt - pv0 !== 1 || err_cnt - err0 !== 0 || last_xm !== 9'h001 ||
        last_ym !== 9'h1FF || last_btn !== 3'b100)
      $display("FAIL glitch_packet: pv=%0d err=%0d xm=%h ym=%h btn=%b want 1 0 001 1ff 100",
               pv_cnt - pv0, err_cnt - err0, last_xm, last_ym, last_btn);
    else passes++;
  endtask

  task automatic test_mid_reset;
    int pv0, err0;
    send_frame(8'h09, 1'b0, 11);
    send_frame(8'h11, 1'b0, 11);
    rst = 1'b1;
    wait_clk(3);
    checks++;
    if ({xm, ym, btn_mid, btn_right, btn_left, packet_valid, frame_err} !== 23'd0)
      $display("FAIL midreset_outputs: got %h want 0",
               {xm, ym, btn_mid, btn_right, btn_left, packet_valid, frame_err});
    else passes++;
    rst = 1'b0;
    wait_clk(5);
    pv0  = pv_cnt;
    err0 = err_cnt;
    send_frame(8'h04, 1'b0, 11);
    wait_clk(40);
    checks++;
    if (pv_cnt - pv0 !== 0 || err_cnt - err0 !== 0 || btn_left !== 1'b0)
      $display("FAIL midreset_discard: pv=%0d err=%0d btn_left=%b want 0 0 0",
               pv_cnt - pv0, err_cnt - err0, btn_left);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_valid_packet();
    test_parity_error();
    test_resync();
    test_overflow();
    test_timeout();
    test_glitch();
    test_mid_reset();
    checks++;
    if (both_bad !== 0) $display("FAIL exclusive_pulses: got %0d want 0", both_bad);
    else passes++;
    checks++;
    if (nz_bad !== 0) $display("FAIL deltas_outside_strobe: got %0d want 0", nz_bad);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
